ksa_phase_sequencer: RTL and testbench

Sequences the RC4 key-scheduling phases (identity fill, key shuffle, second shuffle, S readout) and time-shares the single-port S memory between them. Issues one-cycle start pulses to each phase engine in order, waits for its done flag, and routes exactly one engine's address/data/write-enable onto the S memory port at a time. Sits between the phase engines and the `s_memory` instance in the top level. Replaces ad-hoc state decoding and muxing there.

---
 rtl/ksa_pkg.sv | 23 ++
 rtl/s_mem_port_mux.sv | 32 +++
 rtl/ksa_phase_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ksa_phase_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// rtl/ksa_pkg.sv - shared types and constants for the RC4 key-scheduling sequencer
package ksa_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    ABORT = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  // Phase indices, run in this order
  localparam int PH_FILL     = 0;
  localparam int PH_SHUFFLE  = 1;
  localparam int PH_SHUFFLE2 = 2;
  localparam int PH_READ     = 3;

  // Default S memory geometry (256 x 8)
  localparam int KSA_ADDR_W = 8;
  localparam int KSA_DATA_W = 8;

endpackage

// File: rtl/s_mem_port_mux.sv
// rtl/s_mem_port_mux.sv - combinational select of one packed S memory requester, zero when disabled
module s_mem_port_mux #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 2
) (
  input  logic [SEL_W-1:0]          sel_i,
  input  logic                      en_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_wren_i,
  output logic [ADDR_W-1:0]         mem_address_o,
  output logic [DATA_W-1:0]         mem_data_o,
  output logic                      mem_wren_o
);

  // Pick requester sel_i; a disabled mux or an out-of-range index drives all zeros
  always_comb begin
    mem_address_o = '0;
    mem_data_o    = '0;
    mem_wren_o    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en_i && (sel_i == SEL_W'(i))) begin
        mem_address_o = req_address_i[i*ADDR_W +: ADDR_W];
        mem_data_o    = req_data_i[i*DATA_W +: DATA_W];
        mem_wren_o    = req_wren_i[i];
      end
    end
  end

endmodule

// File: rtl/ksa_phase_sequencer.sv
// rtl/ksa_phase_sequencer.sv - RC4 KSA phase sequencer and S memory port owner (watchdog: KSA_SEQ_WATCHDOG_EN)
module ksa_phase_sequencer
  import ksa_pkg::*;
#(
  parameter int NUM_PHASES     = 4,
  parameter int ADDR_W         = KSA_ADDR_W,
  parameter int DATA_W         = KSA_DATA_W,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int PW            = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         go,
  input  logic                         abort,
  input  logic [NUM_PHASES-1:0]        phase_done,
  input  logic [NUM_PHASES*ADDR_W-1:0] req_address,
  input  logic [NUM_PHASES*DATA_W-1:0] req_data,
  input  logic [NUM_PHASES-1:0]        req_wren,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W-1:0]            mem_data,
  output logic                         mem_wren,
  output logic [NUM_PHASES-1:0]        phase_start,
  output logic                         phase_reset,
  output logic [PW-1:0]                current_phase,
  output logic                         busy,
  output logic                         all_done,
  output logic                         timeout
);

  localparam logic [PW-1:0] P_LAST = PW'(NUM_PHASES - 1);

  seq_state_t                state_q, state_d;
  logic [PW-1:0]             p_q, p_d;
  logic [NUM_PHASES-1:0]     phase_start_q;
  logic                      phase_reset_q;
  logic                      busy_q;
  logic                      all_done_q;
  logic                      done_p;
  logic                      wd_expire;
  logic                      mux_en;

  // Only the selected engine's done flag matters
  assign done_p = phase_done[p_q];

  // Next state and phase index; abort beats done beats go
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          p_d     = '0;
          state_d = START;
        end
      end
      START: begin
        state_d = abort ? ABORT : RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = ABORT;
        end else if (done_p) begin
          if (p_q == P_LAST) begin
            state_d = DONE;
          end else begin
            p_d     = p_q + 1'b1;
            state_d = START;
          end
        end else if (wd_expire) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        state_d = IDLE;
      end
      DONE: begin
        if (abort) begin
          state_d = ABORT;
        end else if (go) begin
          p_d     = '0;
          state_d = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, phase index and registered Moore outputs decoded from the next state
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      p_q           <= '0;
      phase_start_q <= '0;
      phase_reset_q <= 1'b0;
      busy_q        <= 1'b0;
      all_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      phase_start_q <= (state_d == START) ? (NUM_PHASES'(1) << p_d) : '0;
      phase_reset_q <= (state_d == ABORT);
      busy_q        <= (state_d == START) || (state_d == RUN) || (state_d == ABORT);
      all_done_q    <= (state_d == DONE);
    end
  end

`ifdef KSA_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_q;
  logic            go_accept;

  assign go_accept = (state_d == START) && ((state_q == IDLE) || (state_q == DONE));
  assign wd_expire = (state_q == RUN) && !done_p && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  // RUN-cycle counter (zero on RUN entry) and sticky timeout cleared by an accepted go
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == RUN) ? wd_cnt_q + 1'b1 : '0;
      if (go_accept) begin
        timeout_q <= 1'b0;
      end else if (wd_expire && !abort) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign mux_en = (state_q == START) || (state_q == RUN);

  s_mem_port_mux #(
    .NUM_REQ (NUM_PHASES),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .SEL_W   (PW)
  ) u_port_mux (
    .sel_i         (p_q),
    .en_i          (mux_en),
    .req_address_i (req_address),
    .req_data_i    (req_data),
    .req_wren_i    (req_wren),
    .mem_address_o (mem_address),
    .mem_data_o    (mem_data),
    .mem_wren_o    (mem_wren)
  );

  assign phase_start   = phase_start_q;
  assign phase_reset   = phase_reset_q;
  assign busy          = busy_q;
  assign all_done      = all_done_q;
  assign current_phase = p_q;

endmodule

// File: tb/tb_ksa_phase_sequencer.sv
// tb/tb_ksa_phase_sequencer.sv - self-checking bench for ksa_phase_sequencer
module tb_ksa_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  pd = '0;
  logic [31:0] ra_bus = '0;
  logic [31:0] rd_bus = '0;
  logic [3:0]  rw_bus = '0;
  logic [7:0]  ma;
  logic [7:0]  md;
  logic        mw;
  logic [3:0]  ps;
  logic        prst;
  logic [1:0]  cp;
  logic        busy;
  logic        ad;
  logic        to;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  ksa_phase_sequencer #(
    .NUM_PHASES     (4),
    .ADDR_W         (8),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (rst),
    .go            (go),
    .abort         (abort),
    .phase_done    (pd),
    .req_address   (ra_bus),
    .req_data      (rd_bus),
    .req_wren      (rw_bus),
    .mem_address   (ma),
    .mem_data      (md),
    .mem_wren      (mw),
    .phase_start   (ps),
    .phase_reset   (prst),
    .current_phase (cp),
    .busy          (busy),
    .all_done      (ad),
    .timeout       (to)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Random requester fields; optionally pin requester 1 to a known pattern that no other requester shares
  task automatic rand_reqs(input bit fix1);
    for (int k = 0; k < 4; k++) begin
      ra_bus[k*8 +: 8] = 8'($urandom);
      rd_bus[k*8 +: 8] = 8'($urandom);
      rw_bus[k]        = 1'($urandom);
    end
    if (fix1) begin
      ra_bus[15:8] = 8'h5A;
      rd_bus[15:8] = 8'hC3;
      rw_bus[1]    = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (k != 1) begin
          if (ra_bus[k*8 +: 8] == 8'h5A) ra_bus[k*8 +: 8] = 8'hA5;
          if (rd_bus[k*8 +: 8] == 8'hC3) rd_bus[k*8 +: 8] = 8'h3C;
          rw_bus[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".start"}, 32'(ps), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".all_done"}, 32'(ad), 32'h0);
    chk({tag, ".phase_reset"}, 32'(prst), 32'h0);
    chk({tag, ".mem_addr"}, 32'(ma), 32'h0);
    chk({tag, ".mem_data"}, 32'(md), 32'h0);
    chk({tag, ".mem_wren"}, 32'(mw), 32'h0);
  endtask

  // One full run. Engine k reports done after spending dly[k] RUN cycles without it,
  // so starts are spaced dly+2 apart. abort_ph>=0 drives abort together with that
  // phase's done flag. noise holds done[3] during phase 0 and pulses done[0] in START.
  task automatic do_run(input int d0, input int d1, input int d2, input int d3,
                        input int abort_ph, input bit fix1, input bit noise);
    int dly [4];
    int st [4];
    int s_end, a_step, last, act, ecp;
    logic [3:0] es;
    logic eb, ead, er;
    logic [7:0] ea, ed;
    logic ew;
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    go = 1'b1;
    rand_reqs(fix1);
    st[0] = cyc + 1;
    for (int k = 1; k < 4; k++) st[k] = st[k-1] + 2 + dly[k-1];
    s_end  = st[3] + 2 + dly[3];
    a_step = (abort_ph >= 0) ? st[abort_ph] + 1 + dly[abort_ph] : 32'h7fff_ffff;
    last   = (abort_ph >= 0) ? a_step + 4 : s_end + 2;
    ecp    = 0;
    tick();
    go = 1'b0;
    while (cyc <= last) begin
      es = '0; eb = 1'b0; ead = 1'b0; er = 1'b0; act = -1;
      if (cyc > a_step) begin
        er  = (cyc == a_step + 1);
        eb  = er;
        ecp = abort_ph;
      end else if (cyc >= s_end) begin
        ead = 1'b1;
        ecp = 3;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (cyc >= st[k] && cyc <= st[k] + 1 + dly[k]) begin
            act = k;
            ecp = k;
            eb  = 1'b1;
            if (cyc == st[k]) es = 4'(1 << k);
          end
        end
      end
      ea = (act >= 0) ? ra_bus[act*8 +: 8] : 8'h0;
      ed = (act >= 0) ? rd_bus[act*8 +: 8] : 8'h0;
      ew = (act >= 0) ? rw_bus[act] : 1'b0;
      chk("run.start", 32'(ps), 32'(es));
      chk("run.busy", 32'(busy), 32'(eb));
      chk("run.all_done", 32'(ad), 32'(ead));
      chk("run.phase_reset", 32'(prst), 32'(er));
      chk("run.cur_phase", 32'(cp), 32'(ecp));
      chk("run.timeout", 32'(to), 32'h0);
      chk("run.mem_addr", 32'(ma), 32'(ea));
      chk("run.mem_data", 32'(md), 32'(ed));
      chk("run.mem_wren", 32'(mw), 32'(ew));
      if (fix1 && act == 1) begin
        chk("fix1.addr", 32'(ma), 32'h5A);
        chk("fix1.data", 32'(md), 32'hC3);
        chk("fix1.wren", 32'(mw), 32'h1);
      end
      pd = '0;
      for (int k = 0; k < 4; k++) if (cyc == st[k] + 1 + dly[k]) pd[k] = 1'b1;
      if (noise) begin
        if (cyc == st[0]) pd[0] = 1'b1;
        if (cyc < st[1]) pd[3] = 1'b1;
      end
      abort = (cyc == a_step);
      rand_reqs(fix1);
      tick();
    end
    pd = '0;
    abort = 1'b0;
  endtask

  initial begin
    // reset state while held and just after release
    rand_reqs(1'b0);
    tick();
    chk_idle_outputs("reset_held");
    chk("reset_held.cur_phase", 32'(cp), 32'h0);
    chk("reset_held.timeout", 32'(to), 32'h0);
    rst = 1'b0;
    tick();
    chk_idle_outputs("reset_rel");
    chk("reset_rel.cur_phase", 32'(cp), 32'h0);

    // abort in IDLE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk_idle_outputs("idle_abort");

    // engines done after 3 RUN cycles: starts spaced 5 apart
    do_run(3, 3, 3, 3, -1, 1'b0, 1'b0);
    // immediate done, restarted from DONE: 2*4+1 cycles go to all_done
    do_run(0, 0, 0, 0, -1, 1'b0, 1'b0);
    // requester 1 pinned to 5A/C3/1
    do_run(2, 4, 1, 3, -1, 1'b1, 1'b0);
    // abort together with done[2] in RUN of phase 2
    do_run(0, 0, 4, 0, 2, 1'b0, 1'b0);
    // stray done[3] in phase 0 and done[0] in START
    do_run(2, 1, 1, 1, -1, 1'b0, 1'b1);
    // randomized runs
    for (int r = 0; r < 6; r++) begin
      int ap;
      ap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_run(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
             ap, 1'($urandom), 1'($urandom));
    end

    // reset asserted mid-RUN, then released: everything idle and no start without go
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    chk("midrun.busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("midrun_async");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_idle_outputs("midrun_rel");
    chk("midrun_rel.cur_phase", 32'(cp), 32'h0);
    for (int i = 0; i < 4; i++) begin
      rand_reqs(1'b0);
      tick();
      chk("midrun_wait.start", 32'(ps), 32'h0);
      chk("midrun_wait.busy", 32'(busy), 32'h0);
    end

`ifdef KSA_SEQ_WATCHDOG_EN
    // phase 1 never reports done: ABORT and sticky timeout 16 cycles after RUN entry
    begin
      int s1;
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("wd.start0", 32'(ps), 32'h1);
      tick();
      pd = 4'b0001;
      tick();
      pd = 4'b0000;
      chk("wd.start1", 32'(ps), 32'h2);
      s1 = cyc;
      for (int i = 1; i <= 20; i++) begin
        tick();
        chk("wd.phase_reset", 32'(prst), 32'(cyc == s1 + 17));
        chk("wd.timeout", 32'(to), 32'(cyc >= s1 + 17));
        chk("wd.busy", 32'(busy), 32'(cyc <= s1 + 17));
        chk("wd.start", 32'(ps), 32'h0);
      end
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("wd.rego_timeout", 32'(to), 32'h0);
      chk("wd.rego_start0", 32'(ps), 32'h1);
      chk("wd.rego_phase", 32'(cp), 32'h0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time limit so the bench always ends
  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1);
  end

endmodule
